// File: rtl/fact_pkg.sv
// Shared types and register map for the factorial accelerator initiator.
package fact_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_N,
    WR_GO1,
    WR_GO0,
    HOLD,
    POLL,
    RD_RES,
    FIN
  } state_t;

  localparam logic [1:0] ADDR_N   = 2'd0;
  localparam logic [1:0] ADDR_GO  = 2'd1;
  localparam logic [1:0] ADDR_ST  = 2'd2;
  localparam logic [1:0] ADDR_RES = 2'd3;

  localparam int unsigned ST_DONE = 0;
  localparam int unsigned ST_ERR  = 1;

endpackage

// File: rtl/fact_init_timer.sv
// Poll-cycle counter; flags expiry once TIMEOUT polls have been spent.
module fact_init_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  // Saturates at TIMEOUT-1 so a stalled FSM never wraps the count.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_c = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fact_initiator.sv
// Host-side initiator: writes N, pulses Go, polls status, returns the result.
// Optional poll timeout is compiled in with FACT_INIT_TIMEOUT_EN.
module fact_initiator
  import fact_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned NW = 4
`ifdef FACT_INIT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 1024
`endif
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req,
  input  logic [NW-1:0] N_In,
  output logic          Busy,
  output logic          Valid,
  output logic [W-1:0]  Result,
  output logic          Err_Out,
  output logic [1:0]    A,
  output logic          WE,
  output logic [W-1:0]  WD,
  input  logic [W-1:0]  RD
);

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [W-1:0]  result_d, wd_d;
  logic          err_d, valid_d, busy_d, we_d;
  logic [1:0]    a_d;
  logic          timeout_c;

`ifdef FACT_INIT_TIMEOUT_EN
  fact_init_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .Clk       (Clk),
    .Rst       (Rst),
    .clr       (state_q != POLL),
    .en        (state_q == POLL),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, captured operand/result, and bus outputs decoded from the next state
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    result_d = Result;
    err_d    = Err_Out;
    a_d      = A;
    we_d     = 1'b0;
    wd_d     = WD;

    case (state_q)
      IDLE: begin
        if (Req) begin
          n_d     = N_In;
          state_d = WR_N;
        end
      end
      WR_N:   state_d = WR_GO1;
      WR_GO1: state_d = WR_GO0;
      WR_GO0: state_d = HOLD;
      HOLD:   state_d = POLL;
      POLL: begin
        if (RD[ST_ERR]) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = FIN;
        end else if (RD[ST_DONE]) begin
          state_d = RD_RES;
        end else if (timeout_c) begin
          err_d    = 1'b1;
          result_d = '1;
          state_d  = FIN;
        end
      end
      RD_RES: begin
        result_d = RD;
        err_d    = 1'b0;
        state_d  = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      WR_N: begin
        a_d  = ADDR_N;
        we_d = 1'b1;
        wd_d = W'(n_d);
      end
      WR_GO1: begin
        a_d  = ADDR_GO;
        we_d = 1'b1;
        wd_d = W'(1);
      end
      WR_GO0: begin
        a_d  = ADDR_GO;
        we_d = 1'b1;
        wd_d = '0;
      end
      HOLD, POLL: a_d = ADDR_ST;
      RD_RES:     a_d = ADDR_RES;
      default:    a_d = A;
    endcase

    valid_d = (state_d == FIN);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      n_q     <= '0;
      Busy    <= 1'b0;
      Valid   <= 1'b0;
      Result  <= '0;
      Err_Out <= 1'b0;
      A       <= '0;
      WE      <= 1'b0;
      WD      <= '0;
    end else begin
      n_q     <= n_d;
      Busy    <= busy_d;
      Valid   <= valid_d;
      Result  <= result_d;
      Err_Out <= err_d;
      A       <= a_d;
      WE      <= we_d;
      WD      <= wd_d;
    end
  end

endmodule

// File: tb/tb_fact_initiator.sv
// Directed bench for fact_initiator against a small factorial accelerator model.
module tb_fact_initiator;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req;
  logic [3:0]  N_In;
  logic        Busy, Valid, Err_Out, WE;
  logic [31:0] Result, WD;
  logic [31:0] RD;
  logic [1:0]  A;

  int vectors    = 0;
  int miscompares = 0;

  // accelerator model controls and state
  int          lat_cfg;
  logic        force_en;
  logic [1:0]  force_st;
  logic        log_clr;
  logic [31:0] m_n, m_res;
  logic        m_done, m_err, m_pend;
  int          m_cnt;
  logic [33:0] wlog [8];
  int          wcnt, nwr;

  always #5 Clk = ~Clk;

`ifdef FACT_INIT_TIMEOUT_EN
  fact_initiator #(.W(32), .NW(4), .TIMEOUT(8)) dut (
`else
  fact_initiator #(.W(32), .NW(4)) dut (
`endif
    .Clk(Clk), .Rst(Rst), .Req(Req), .N_In(N_In), .Busy(Busy), .Valid(Valid),
    .Result(Result), .Err_Out(Err_Out), .A(A), .WE(WE), .WD(WD), .RD(RD)
  );

  function automatic logic [31:0] fact(input logic [31:0] n);
    logic [31:0] r = 32'd1;
    for (int k = 2; k <= 12; k++) if (32'(k) <= n) r = r * 32'(k);
    return r;
  endfunction

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_n <= '0; m_res <= '0; m_done <= 1'b0; m_err <= 1'b0; m_pend <= 1'b0; m_cnt <= 0;
      wcnt <= 0; nwr <= 0;
    end else begin
      if (log_clr) begin
        wcnt <= 0; nwr <= 0;
      end else if (WE) begin
        if (wcnt < 8) wlog[wcnt] <= {A, WD};
        wcnt <= wcnt + 1;
        if (A == 2'd0) nwr <= nwr + 1;
      end
      if (WE) begin
        if (A == 2'd0) m_n <= WD;
        if (A == 2'd1 && WD[0]) begin
          m_pend <= 1'b1; m_cnt <= lat_cfg; m_done <= 1'b0; m_err <= 1'b0;
        end
      end else if (m_pend) begin
        if (m_cnt == 0) begin
          m_pend <= 1'b0;
          if (m_n > 32'd12) m_err <= 1'b1;
          else begin m_done <= 1'b1; m_res <= fact(m_n); end
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  always_comb begin
    case (A)
      2'd0:    RD = m_n;
      2'd1:    RD = '0;
      2'd2:    RD = force_en ? {30'd0, force_st} : {30'd0, m_err, m_done};
      default: RD = m_res;
    endcase
  end

  task automatic clear_log();
    @(negedge Clk); log_clr = 1'b1;
    @(negedge Clk); log_clr = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] n, input int budget, output logic [31:0] res,
                        output logic err, output int cycles, output bit got);
    @(negedge Clk); Req = 1'b1; N_In = n;
    @(negedge Clk); Req = 1'b0;
    got = 1'b0; cycles = 0; res = '0; err = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      if (Valid === 1'b1) begin
        got = 1'b1; cycles = i; res = Result; err = Err_Out;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    vectors++; if (Busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    vectors++; if (Valid !== 1'b0)   begin miscompares++; $display("FAIL reset_valid: got %b expected 0", Valid); end
    vectors++; if (Result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", Result); end
    vectors++; if (Err_Out !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", Err_Out); end
    vectors++; if (A !== 2'd0)       begin miscompares++; $display("FAIL reset_a: got %0d expected 0", A); end
    vectors++; if (WE !== 1'b0)      begin miscompares++; $display("FAIL reset_we: got %b expected 0", WE); end
    vectors++; if (WD !== 32'd0)     begin miscompares++; $display("FAIL reset_wd: got %h expected 0", WD); end
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    logic [31:0] res; logic err; int cyc; bit got;
    lat_cfg = 0;
    clear_log();
    run_op(4'd5, 200, res, err, cyc, got);
    vectors++; if (got !== 1'b1)     begin miscompares++; $display("FAIL n5_valid: got %b expected 1", got); end
    vectors++; if (res !== 32'd120)  begin miscompares++; $display("FAIL n5_result: got %0d expected 120", res); end
    vectors++; if (err !== 1'b0)     begin miscompares++; $display("FAIL n5_err: got %b expected 0", err); end
    vectors++; if (cyc != 7)         begin miscompares++; $display("FAIL n5_latency: got %0d expected 7", cyc); end
    vectors++; if (wcnt != 3)        begin miscompares++; $display("FAIL n5_write_count: got %0d expected 3", wcnt); end
    vectors++; if (wlog[0] !== {2'd0, 32'd5}) begin miscompares++; $display("FAIL n5_write0: got %h expected %h", wlog[0], {2'd0, 32'd5}); end
    vectors++; if (wlog[1] !== {2'd1, 32'd1}) begin miscompares++; $display("FAIL n5_write1: got %h expected %h", wlog[1], {2'd1, 32'd1}); end
    vectors++; if (wlog[2] !== {2'd1, 32'd0}) begin miscompares++; $display("FAIL n5_write2: got %h expected %h", wlog[2], {2'd1, 32'd0}); end
    @(negedge Clk);
    vectors++; if (Valid !== 1'b0)   begin miscompares++; $display("FAIL n5_valid_pulse: got %b expected 0", Valid); end
    vectors++; if (Busy !== 1'b0)    begin miscompares++; $display("FAIL n5_busy_idle: got %b expected 0", Busy); end
    repeat (5) @(negedge Clk);
    vectors++; if (Result !== 32'd120) begin miscompares++; $display("FAIL n5_result_held: got %0d expected 120", Result); end
  endtask

  task automatic test_values();
    logic [31:0] res; logic err; int cyc; bit got;
    lat_cfg = 2;
    run_op(4'd0, 200, res, err, cyc, got);
    vectors++; if (got !== 1'b1 || res !== 32'd1) begin miscompares++; $display("FAIL n0_result: got %0d valid %b expected 1", res, got); end
    vectors++; if (cyc != 9)        begin miscompares++; $display("FAIL n0_latency: got %0d expected 9", cyc); end
    run_op(4'd12, 200, res, err, cyc, got);
    vectors++; if (got !== 1'b1 || res !== 32'h1C8CFC00) begin miscompares++; $display("FAIL n12_result: got %h valid %b expected 1c8cfc00", res, got); end
    vectors++; if (err !== 1'b0)    begin miscompares++; $display("FAIL n12_err: got %b expected 0", err); end
    lat_cfg = 3;
    run_op(4'd3, 200, res, err, cyc, got);
    vectors++; if (got !== 1'b1 || res !== 32'd6) begin miscompares++; $display("FAIL n3_result: got %0d valid %b expected 6", res, got); end
    vectors++; if (cyc != 10)       begin miscompares++; $display("FAIL n3_latency: got %0d expected 10", cyc); end
  endtask

  task automatic test_error();
    logic [31:0] res; logic err; int cyc; bit got;
    lat_cfg = 0;
    run_op(4'd13, 200, res, err, cyc, got);
    vectors++; if (got !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL n13_err: got %b valid %b expected 1", err, got); end
    vectors++; if (res !== 32'd0)   begin miscompares++; $display("FAIL n13_result: got %h expected 0", res); end
    run_op(4'd4, 200, res, err, cyc, got);
    vectors++; if (res !== 32'd24 || err !== 1'b0) begin miscompares++; $display("FAIL n4_after_err: got %0d err %b expected 24 err 0", res, err); end
    force_en = 1'b1; force_st = 2'b11;
    run_op(4'd2, 200, res, err, cyc, got);
    vectors++; if (got !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL st11_err: got %b valid %b expected 1", err, got); end
    vectors++; if (res !== 32'd0)   begin miscompares++; $display("FAIL st11_result: got %h expected 0", res); end
    force_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    logic [31:0] first_res = '0;
    bool_done: begin end
    lat_cfg = 1;
    clear_log();
    @(negedge Clk); Req = 1'b1; N_In = 4'd4;
    @(negedge Clk); N_In = 4'd9;
    vectors++; if (Result !== 32'd0) begin miscompares++; $display("FAIL b2b_result_kept: got %h expected 0", Result); end
    for (int i = 0; i < 60; i++) begin
      if (Valid === 1'b1) begin
        nvalid++;
        if (nvalid == 1) first_res = Result;
        @(negedge Clk); Req = 1'b0;
      end else @(negedge Clk);
    end
    Req = 1'b0;
    vectors++; if (nvalid != 1)       begin miscompares++; $display("FAIL b2b_valid_count: got %0d expected 1", nvalid); end
    vectors++; if (first_res !== 32'd24) begin miscompares++; $display("FAIL b2b_result: got %0d expected 24", first_res); end
    vectors++; if (nwr != 1)          begin miscompares++; $display("FAIL b2b_n_writes: got %0d expected 1", nwr); end
    vectors++; if (Busy !== 1'b0)     begin miscompares++; $display("FAIL b2b_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] res; logic err; int cyc; bit got;
    int nvalid = 0;
    lat_cfg = 0;
    @(negedge Clk); Req = 1'b1; N_In = 4'd7;
    @(negedge Clk); Req = 1'b0;
    vectors++; if (WE !== 1'b1) begin miscompares++; $display("FAIL rst_wr_we_before: got %b expected 1", WE); end
    Rst = 1'b1; #1;
    vectors++; if (WE !== 1'b0 || Busy !== 1'b0) begin miscompares++; $display("FAIL rst_wr_drop: we %b busy %b expected 0 0", WE, Busy); end
    @(negedge Clk); Rst = 1'b0;
    run_op(4'd5, 200, res, err, cyc, got);
    vectors++; if (res !== 32'd120) begin miscompares++; $display("FAIL rst_pre_result: got %0d expected 120", res); end
    lat_cfg = 20;
    @(negedge Clk); Req = 1'b1; N_In = 4'd6;
    @(negedge Clk); Req = 1'b0;
    repeat (6) @(negedge Clk);
    vectors++; if (Busy !== 1'b1 || A !== 2'd2) begin miscompares++; $display("FAIL rst_in_poll: busy %b a %0d expected 1 2", Busy, A); end
    Rst = 1'b1; #1;
    vectors++; if (WE !== 1'b0 || Busy !== 1'b0 || Valid !== 1'b0) begin miscompares++; $display("FAIL rst_poll_ctrl: we %b busy %b valid %b expected 0 0 0", WE, Busy, Valid); end
    vectors++; if (Result !== 32'd0 || Err_Out !== 1'b0) begin miscompares++; $display("FAIL rst_poll_result: got %h err %b expected 0 0", Result, Err_Out); end
    @(negedge Clk); @(negedge Clk); Rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (Valid === 1'b1) nvalid++;
    end
    vectors++; if (nvalid != 0) begin miscompares++; $display("FAIL rst_no_valid: got %0d expected 0", nvalid); end
    lat_cfg = 0;
    run_op(4'd3, 200, res, err, cyc, got);
    vectors++; if (got !== 1'b1 || res !== 32'd6 || err !== 1'b0) begin miscompares++; $display("FAIL rst_rerun: got %0d err %b valid %b expected 6 0 1", res, err, got); end
  endtask

  task automatic test_timeout();
    logic [31:0] res; logic err; int cyc; bit got;
    force_en = 1'b1; force_st = 2'b00;
`ifdef FACT_INIT_TIMEOUT_EN
    run_op(4'd5, 200, res, err, cyc, got);
    vectors++; if (got !== 1'b1)        begin miscompares++; $display("FAIL to_valid: got %b expected 1", got); end
    vectors++; if (err !== 1'b1)        begin miscompares++; $display("FAIL to_err: got %b expected 1", err); end
    vectors++; if (res !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL to_result: got %h expected ffffffff", res); end
    vectors++; if (cyc != 13)           begin miscompares++; $display("FAIL to_latency: got %0d expected 13", cyc); end
    force_en = 1'b0;
`else
    run_op(4'd5, 60, res, err, cyc, got);
    vectors++; if (got !== 1'b0)  begin miscompares++; $display("FAIL stuck_no_valid: got %b expected 0", got); end
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL stuck_busy: got %b expected 1", Busy); end
    force_en = 1'b0;
    Rst = 1'b1;
    @(negedge Clk); @(negedge Clk); Rst = 1'b0;
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL stuck_recover: got %b expected 0", Busy); end
`endif
  endtask

  initial begin
    Rst = 1'b1; Req = 1'b0; N_In = '0;
    lat_cfg = 0; force_en = 1'b0; force_st = 2'b00; log_clr = 1'b0;
    test_reset();
    test_basic();
    test_values();
    test_error();
    test_back_to_back();
    test_rst_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
